hazard_ctrl_unit: RTL
=====================

// Module: hazard_ctrl_unit
// PURPOSE
//  Pipeline hazard sequencer for the 5-stage RV32I core; sits beside the forwarding logic.
//  - Detects load-use hazards the forwarding paths cannot cover.
//  - Detects taken branches resolved in EX.
//  - Sequences multi-cycle data-memory waits via a req/ready handshake.
//  - Drives per-stage register write enables and flushes.
//  - Holds a sticky fault on memory timeout and keeps stall/flush performance counters.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive wait cycles before FAULT; 0 disables timeout
//  CNT_W        32  width of performance counters
//  WAIT_W        8  width of internal wait counter; MEM_TIMEOUT < 2**WAIT_W
// PORTS
//  clk              in   1      core clock, rising edge
//  rst_n            in   1      asynchronous active-low reset
//  if_id_rs1        in   5      rs1 of instruction in ID
//  if_id_rs2        in   5      rs2 of instruction in ID
//  if_id_use_rs1    in   1      ID instruction reads rs1
//  if_id_use_rs2    in   1      ID instruction reads rs2
//  id_ex_rd         in   5      rd of instruction in EX
//  id_ex_memread    in   1      EX instruction is a load
//  ex_branch_taken  in   1      EX resolved taken branch/jump (redirect PC)
//  mem_req          in   1      MEM-stage instruction accesses data memory
//  mem_ready        in   1      data memory completes access this cycle
//  pc_write         out  1      PC update enable
//  if_id_write      out  1      IF/ID register enable
//  if_id_flush      out  1      load bubble into IF/ID
//  id_ex_write      out  1      ID/EX register enable
//  id_ex_flush      out  1      load bubble into ID/EX
//  ex_mem_write     out  1      EX/MEM register enable
//  mem_wb_flush     out  1      load bubble into MEM/WB
//  fault            out  1      sticky memory-timeout fault
//  stall_cnt        out  CNT_W  cycles with pc_write=0 (excluding reset), saturating
//  flush_cnt        out  CNT_W  branch flush events, saturating
// BEHAVIOUR
//  State
//   - FSM states: RUN, MEM_WAIT, FAULT.
//   - Registered: state, wait_cnt[WAIT_W], fault, stall_cnt, flush_cnt.
//   - Control outputs are combinational from state and inputs (same-cycle effect).
//  Reset (rst_n=0, async)
//   - State: state=RUN, wait_cnt=0, fault=0, counters=0.
//   - Outputs: all *_write=0, all *_flush=1.
//  Conditions
//   - memwait = mem_req & ~mem_ready.
//   - loaduse = id_ex_memread & id_ex_rd!=0 &
//     ((if_id_use_rs1 & rs1==rd) | (if_id_use_rs2 & rs2==rd)).
//  Priority: FAULT > memwait > ex_branch_taken > loaduse > normal.
//  Output actions per case
//   - normal: all writes=1, all flushes=0.
//   - memwait: pc/if_id/id_ex/ex_mem write=0; mem_wb_flush=1; other flushes=0.
//     Branch/loaduse stay frozen in EX/ID and are re-evaluated after the wait.
//   - branch: all writes=1; if_id_flush=1 and id_ex_flush=1 (2-cycle penalty).
//     loaduse in the same cycle is ignored (wrong-path instruction).
//   - loaduse: pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1. One bubble only:
//     the next cycle id_ex_memread=0, so the stall clears naturally.
//   - FAULT: all writes=0; all flushes=1; fault=1. Sticky until rst_n.
//  FSM transitions
//   - RUN -> MEM_WAIT when memwait; wait_cnt<=1.
//   - MEM_WAIT -> RUN when mem_ready (cycle proceeds as normal/branch/loaduse); wait_cnt<=0.
//   - MEM_WAIT: on ~mem_ready, wait_cnt++.
//   - MEM_WAIT -> FAULT when ~mem_ready & wait_cnt==MEM_TIMEOUT-1 (MEM_TIMEOUT != 0).
//   - MEM_WAIT with mem_req dropped: treat as ready, go to RUN.
//   - mem_ready in the first cycle of mem_req: no stall, stays RUN.
//  Counters
//   - stall_cnt +1 each cycle pc_write=0, including FAULT cycles.
//   - flush_cnt +1 per branch-flush cycle.
//   - Both hold at all-ones (no wrap).
//  Misc
//   - rd=x0 never stalls.
//   - Reset mid-wait aborts cleanly to RUN.
// TESTING
//  1. Load x5 in EX, ID reads rs2=x5 (use_rs2=1) -> exactly 1 cycle:
//     pc_write=0, id_ex_flush=1; stall_cnt=1.
//  2. Same as 1 but rd=x0, or use_rs2=0 -> no stall; all writes=1.
//  3. ex_branch_taken=1 with loaduse=1 -> if_id_flush=id_ex_flush=1, pc_write=1; flush_cnt=1.
//  4. mem_req=1, mem_ready low 3 cycles then high -> 3 frozen cycles, mem_wb_flush=1;
//     RUN on 4th; stall_cnt=3.
//  5. MEM_TIMEOUT=4, mem_ready never -> fault=1 after 4 wait cycles; stays frozen;
//     rst_n pulse clears all state.
//  6. Counter saturation (CNT_W=4): 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard sequencer for the 5-stage RV32I core: load-use stalls, branch flushes,
// data-memory wait sequencing with timeout fault, and saturating stall/flush counters.
module hazard_ctrl_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned WAIT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_use_rs1,
    input  logic             if_id_use_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_flush,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_e;

    localparam logic [WAIT_W-1:0] TimeoutLast = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;

    logic memWait;
    logic loadUse;
    logic timeoutHit;
    logic branchFlush;

    assign memWait = mem_req & ~mem_ready;

    // A load writing x0 never produces a usable value, so it can never cause a stall.
    assign loadUse = id_ex_memread && (id_ex_rd != 5'd0) &&
                     ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
                      (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));

    assign timeoutHit = (MEM_TIMEOUT != 0) && (waitCnt_q >= TimeoutLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            waitCnt_q  <= '0;
            fault_q    <= 1'b0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            fault_q    <= fault_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    // The cycle that first sees memWait counts as wait cycle 1; dropping mem_req acts as ready.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        fault_d   = fault_q;
        unique case (state_q)
            RUN: begin
                if (memWait) begin
                    if (MEM_TIMEOUT == 1) begin
                        state_d   = FAULT;
                        fault_d   = 1'b1;
                        waitCnt_d = '0;
                    end else begin
                        state_d   = MEM_WAIT;
                        waitCnt_d = WAIT_W'(1);
                    end
                end
            end
            MEM_WAIT: begin
                if (!memWait) begin
                    state_d   = RUN;
                    waitCnt_d = '0;
                end else if (timeoutHit) begin
                    state_d   = FAULT;
                    fault_d   = 1'b1;
                    waitCnt_d = '0;
                end else if (waitCnt_q != '1) begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            FAULT: begin
                state_d = FAULT;
                fault_d = 1'b1;
            end
            default: begin
                state_d   = RUN;
                waitCnt_d = '0;
            end
        endcase
    end

    // A pending branch or load-use stays frozen during a memory wait and resolves afterwards.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;
        branchFlush  = 1'b0;
        if (!rst_n || (state_q == FAULT)) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b0;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (memWait) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            branchFlush = 1'b1;
        end else if (loadUse) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (!pc_write && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
        if (branchFlush && (flushCnt_q != '1)) begin
            flushCnt_d = flushCnt_q + CNT_W'(1);
        end
    end

    assign fault     = fault_q;
    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;

endmodule
